// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// Optional macro DIV_FAST_PATH_EN: one-cycle completion when |dividend| < |divisor|.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    // state  | meaning
    // FREE   | idle, waiting for start_i
    // BYZERO | divisor was zero, result forced to 0
    // ON     | one restoring step per clock
    // END    | result valid, held until start_i drops
    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_dividend;
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quot;
    logic                r_sign_a;
    logic                r_sign_b;
    logic                r_signed;
    logic [2*DATA_W-1:0] r_result;
    logic [2*DATA_W-1:0] w_result_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic                w_load;
    logic                w_step;

    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_partial;
    logic [DATA_W:0]     w_sub;
    logic [DATA_W-1:0]   w_quot_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    assign w_abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Partial remainder is always below the divisor, so the shifted value fits
    // in DATA_W+1 bits and the top bit of the difference is the borrow.
    assign w_partial = {r_rem, r_dividend[DATA_W-1]};
    assign w_sub     = w_partial - {1'b0, r_divisor};

    assign w_quot_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -r_quot : r_quot;
    assign w_rem_fix  = (r_signed && r_sign_a) ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_FREE: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = S_BYZERO;
                    end
`ifdef DIV_FAST_PATH_EN
                    else if (w_abs_a < w_abs_b) begin
                        w_state_nxt  = S_END;
                        w_result_nxt = {opdata1_i, {DATA_W{1'b0}}};
                        w_ready_nxt  = 1'b1;
                    end
`endif
                    else begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = '0;
                        w_load      = 1'b1;
                    end
                end
            end
            S_BYZERO: begin
                w_state_nxt  = S_END;
                w_result_nxt = '0;
                w_ready_nxt  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = S_END;
                    w_result_nxt = {w_rem_fix, w_quot_fix};
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_step    = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_END: begin
                if (!start_i) begin
                    w_state_nxt  = S_FREE;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = S_FREE;
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_signed   <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
            if (w_load) begin
                r_dividend <= w_abs_a;
                r_divisor  <= w_abs_b;
                r_rem      <= '0;
                r_quot     <= '0;
                r_sign_a   <= signed_div_i & opdata1_i[DATA_W-1];
                r_sign_b   <= signed_div_i & opdata2_i[DATA_W-1];
                r_signed   <= signed_div_i;
            end else if (w_step) begin
                r_dividend <= {r_dividend[DATA_W-2:0], 1'b0};
                r_rem      <= w_sub[DATA_W] ? w_partial[DATA_W-1:0] : w_sub[DATA_W-1:0];
                r_quot     <= {r_quot[DATA_W-2:0], ~w_sub[DATA_W]};
            end
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
